// File: rtl/data_sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data SRAM bridge.
// Holds the FSM state type and the pipeline-wide signal values.
package data_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic        STOP        = 1'b1;
    localparam logic        NOSTOP      = 1'b0;
    localparam logic        CHIPENABLE  = 1'b1;
    localparam logic        WRITEENABLE = 1'b1;
    localparam logic [31:0] ZEROWORD    = 32'h0000_0000;
    localparam int          SRAM_ADDR_W = 18;

endpackage

// File: rtl/data_sram_ctrl.sv
// MEM-stage to single-port SRAM bridge with variable ack latency.
// Registers one request, stalls the pipe until ack/timeout, returns read data.
module data_sram_ctrl
    import data_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [31:0]       mem_data_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [3:0]        sram_be_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i,
    input  logic              sram_ack_i
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hold;
    logic             accept;
    logic             at_max;
    logic             rd_cap;
    logic             tmo_err;
    logic             req_drop;
    logic             cnt_inc;
    logic             unused_addr;

    assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    assign at_max = (cnt == CNT_MAX);
    assign accept = (state == S_IDLE) && (mem_ce_i == CHIPENABLE) && !flush_i;

    assign stallreq_o = (accept || state == S_WAIT || state == S_DRAIN)
                      ? STOP : NOSTOP;
    assign mem_data_o = hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        rd_cap   = 1'b0;
        tmo_err  = 1'b0;
        req_drop = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // ack beats both flush-to-drain and timeout
                if (sram_ack_i) begin
                    req_drop = 1'b1;
                    if (flush_i) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DONE;
                        rd_cap  = (sram_we_o != WRITEENABLE);
                    end
                end else if (flush_i) begin
                    state_n = S_DRAIN;
                end else if (at_max) begin
                    req_drop = 1'b1;
                    tmo_err  = 1'b1;
                    state_n  = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (sram_ack_i || at_max) begin
                    req_drop = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DONE: begin
                if (flush_i || !stall_i) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_req_o   <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_be_o    <= 4'h0;
            sram_wdata_o <= ZEROWORD;
            hold         <= ZEROWORD;
            bus_err_o    <= 1'b0;
            cnt          <= '0;
        end else begin
            bus_err_o <= 1'b0;
            if (accept) begin
                sram_req_o   <= 1'b1;
                sram_we_o    <= mem_we_i;
                sram_addr_o  <= mem_addr_i[ADDR_W+1:2];
                sram_be_o    <= mem_sel_i;
                sram_wdata_o <= mem_data_i;
                cnt          <= '0;
            end
            if (req_drop) begin
                sram_req_o <= 1'b0;
            end
            if (rd_cap) begin
                hold <= sram_rdata_i;
            end
            if (tmo_err) begin
                hold      <= ZEROWORD;
                bus_err_o <= 1'b1;
            end
            if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: cycle vector table, directed corner cases,
// and random transactions against a behavioural SRAM + reference memory.
module tb_data_sram_ctrl;

    localparam int AW  = 18;
    localparam int TMO = 8;

    logic          clk;
    logic          rst;
    logic          mem_ce_i;
    logic          mem_we_i;
    logic [31:0]   mem_addr_i;
    logic [3:0]    mem_sel_i;
    logic [31:0]   mem_data_i;
    logic          stall_i;
    logic          flush_i;
    logic [31:0]   mem_data_o;
    logic          stallreq_o;
    logic          bus_err_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [3:0]    sram_be_o;
    logic [31:0]   sram_wdata_o;
    logic [31:0]   sram_rdata_i;
    logic          sram_ack_i;

    data_sram_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_ce_i     (mem_ce_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_sel_i    (mem_sel_i),
        .mem_data_i   (mem_data_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .mem_data_o   (mem_data_o),
        .stallreq_o   (stallreq_o),
        .bus_err_o    (bus_err_o),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_be_o    (sram_be_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .sram_ack_i   (sram_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hold;
    logic [31:0] sram_mem [16];
    logic [31:0] ref_mem  [16];

    typedef struct {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic        stall;
        logic        flush;
        logic        ack;
        logic [31:0] rd;
        logic        x_sr;
        logic        x_req;
        logic [31:0] x_data;
        logic        x_err;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ce, input logic we,
        input logic [31:0] addr, input logic stall, input logic flush,
        input logic ack, input logic [31:0] rd, input logic x_sr,
        input logic x_req, input logic [31:0] x_data, input logic x_err);
        vec_t v;
        v.ce = ce; v.we = we; v.addr = addr; v.stall = stall;
        v.flush = flush; v.ack = ack; v.rd = rd; v.x_sr = x_sr;
        v.x_req = x_req; v.x_data = x_data; v.x_err = x_err;
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
        input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // k = cycles from request to ack (0 = never); nstall = extra DONE cycles
    task automatic run_txn(input logic we, input logic [31:0] addr,
        input logic [3:0] sel, input logic [31:0] wd, input int k,
        input int nstall);
        int          idx;
        bit          to;
        int          exp_st;
        int          st;
        int          i;
        bit          done;
        logic [31:0] exp_out;
        idx     = int'(addr[5:2]);
        to      = (k == 0) || (k > TMO + 1);
        exp_st  = to ? TMO + 2 : k + 1;
        exp_out = to ? 32'h0 : (we ? exp_hold : ref_mem[idx]);
        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
        mem_sel_i = sel; mem_data_i = wd; stall_i = 1'b0;
        flush_i = 1'b0; sram_ack_i = 1'b0; sram_rdata_i = $urandom;
        @(negedge clk);
        chk("txn_accept_stall", 32'(stallreq_o), 32'd1);
        st = 1; done = 0; i = 0;
        while (!done) begin
            i++;
            @(posedge clk); #1;
            mem_ce_i = 1'b0; mem_we_i = ~we; mem_addr_i = $urandom;
            mem_sel_i = ~sel; mem_data_i = $urandom;
            stall_i = (nstall > 0);
            sram_ack_i = (i == k);
            sram_rdata_i = sram_ack_i ? sram_mem[sram_addr_o[3:0]]
                                      : $urandom;
            @(negedge clk);
            if (stallreq_o) begin
                st++;
                chk("wait_req", 32'(sram_req_o), 32'd1);
                chk("wait_we", 32'(sram_we_o), 32'(we));
                chk("wait_addr", 32'(sram_addr_o), 32'(addr[AW+1:2]));
                chk("wait_be", 32'(sram_be_o), 32'(sel));
                chk("wait_wdata", sram_wdata_o, wd);
                chk("wait_no_err", 32'(bus_err_o), 32'd0);
                if (sram_ack_i && sram_req_o && sram_we_o)
                    sram_mem[sram_addr_o[3:0]] = merge(
                        sram_mem[sram_addr_o[3:0]], sram_wdata_o, sram_be_o);
                if (i > TMO + 3) begin
                    checks++; errors++;
                    $display("FAIL no_done stall cycles %0d want %0d",
                             st, exp_st);
                    done = 1;
                end
            end else begin
                done = 1;
            end
        end
        chk("stall_cycles", 32'(st), 32'(exp_st));
        chk("done_data", mem_data_o, exp_out);
        chk("done_bus_err", 32'(bus_err_o), 32'(to));
        chk("done_req", 32'(sram_req_o), 32'd0);
        if (we && !to) ref_mem[idx] = merge(ref_mem[idx], wd, sel);
        exp_hold = exp_out;
        for (int j = 0; j < nstall; j++) begin
            @(posedge clk); #1;
            mem_ce_i = 1'b1; mem_addr_i = $urandom & 32'h3F;
            stall_i = (j < nstall - 1); sram_ack_i = 1'b0;
            @(negedge clk);
            chk("held_stallreq", 32'(stallreq_o), 32'd0);
            chk("held_no_reissue", 32'(sram_req_o), 32'd0);
            chk("held_data", mem_data_o, exp_hold);
            chk("held_err", 32'(bus_err_o), 32'd0);
        end
        @(posedge clk); #1;
        mem_ce_i = 1'b0; stall_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] selv [7];
        int         r;
        int         k;
        selv = '{4'hF, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC};

        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end

        rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
        mem_sel_i = '0; mem_data_i = '0; stall_i = 1'b0; flush_i = 1'b0;
        sram_rdata_i = '0; sram_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", mem_data_o, 32'h0);
        chk("rst_stallreq", 32'(stallreq_o), 32'd0);
        chk("rst_err", 32'(bus_err_o), 32'd0);
        chk("rst_req", 32'(sram_req_o), 32'd0);
        chk("rst_we", 32'(sram_we_o), 32'd0);
        chk("rst_addr", 32'(sram_addr_o), 32'd0);
        chk("rst_be", 32'(sram_be_o), 32'd0);
        chk("rst_wdata", sram_wdata_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        tbl[0]  = mk(1, 0, 32'h20, 0, 0, 0, 0, 1, 0, 32'h0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 32'h1234_5678, 1, 1, 32'h0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0);
        tbl[4]  = mk(1, 0, 32'h24, 0, 0, 0, 0, 1, 0, 32'h1234_5678, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h1234_5678, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234_5678, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1234_5678, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1, 32'h1234_5678, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0);
        tbl[10] = mk(1, 0, 32'h28, 0, 0, 0, 0, 1, 0, 32'h1234_5678, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, 1, 32'h1234_5678, 0);
        tbl[12] = mk(1, 0, 32'h2C, 0, 0, 0, 0, 1, 0, 32'h1234_5678, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 32'h0000_00AB, 1, 1, 32'h1234_5678, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_00AB, 0);
        tbl[15] = mk(1, 0, 32'h30, 0, 0, 0, 0, 1, 0, 32'h0000_00AB, 0);
        tbl[16] = mk(1, 0, 32'h30, 0, 0, 1, 32'h5555_AAAA, 1, 1, 32'h0000_00AB, 0);
        for (int i = 17; i < 21; i++)
            tbl[i] = mk(1, 0, 32'h30, 1, 0, 0, 0, 0, 0, 32'h5555_AAAA, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555_AAAA, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5555_AAAA, 0);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            mem_ce_i = tbl[i].ce; mem_we_i = tbl[i].we;
            mem_addr_i = tbl[i].addr; mem_sel_i = 4'hF;
            mem_data_i = 32'h0; stall_i = tbl[i].stall;
            flush_i = tbl[i].flush; sram_ack_i = tbl[i].ack;
            sram_rdata_i = tbl[i].rd;
            @(negedge clk);
            chk($sformatf("v%0d_stallreq", i), 32'(stallreq_o),
                32'(tbl[i].x_sr));
            chk($sformatf("v%0d_req", i), 32'(sram_req_o),
                32'(tbl[i].x_req));
            chk($sformatf("v%0d_data", i), mem_data_o, tbl[i].x_data);
            chk($sformatf("v%0d_err", i), 32'(bus_err_o),
                32'(tbl[i].x_err));
        end
        exp_hold = 32'h5555_AAAA;

        run_txn(1'b1, 32'h0000_0010, 4'hF, 32'hCAFE_F00D, 5, 0);
        run_txn(1'b1, 32'h0000_0003, 4'h1, 32'hEEEE_EEEE, 2, 0);
        run_txn(1'b0, 32'h0000_0000, 4'h1, 32'h0, 1, 0);
        chk("lb_low_byte", 32'(mem_data_o[7:0]), 32'h0000_00EE);
        run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 0, 0);
        run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, TMO + 1, 0);
        run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 1, 5);

        @(posedge clk); #1;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h8;
        mem_sel_i = 4'hF; mem_data_i = 32'h1111_2222;
        @(negedge clk);
        @(posedge clk); #1;
        mem_ce_i = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("wait_before_rst", 32'(sram_req_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", 32'(sram_req_o), 32'd0);
        chk("midrst_stallreq", 32'(stallreq_o), 32'd0);
        chk("midrst_data", mem_data_o, 32'h0);
        chk("midrst_addr", 32'(sram_addr_o), 32'd0);
        chk("midrst_we", 32'(sram_we_o), 32'd0);
        chk("midrst_wdata", sram_wdata_o, 32'h0);
        exp_hold = 32'h0;

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) k = 0;
            else if (r == 1) k = TMO + 1;
            else if (r == 2) k = TMO + 2;
            else k = $urandom_range(1, 5);
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 63),
                    selv[$urandom_range(0, 6)], $urandom, k,
                    $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
